imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage of the RISC-V pipeline.
- Accepts raw instructions over a valid/ready handshake and decodes the opcode internally.
- Produces a sign-extended XLEN-bit immediate, a format code and an illegal-opcode flag, one cycle later.
- A 2-entry skid buffer sustains full throughput under backpressure. Supports pipeline flush and keeps a saturating count of illegal opcodes.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- CNT_W, 8, width of the saturating illegal-instruction counter.
- SUPPORT_SYSTEM, 0, when 1 opcode 0x73 decodes as I-format and is legal; when 0 it is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- flush_i  input  1  discards all held and incoming entries.
- valid_i  input  1  instruction_i is valid.
- ready_o  output  1  block can accept an instruction this cycle.
- instruction_i  input  32  raw instruction word.
- valid_o  output  1  outputs hold a decoded entry.
- ready_i  input  1  downstream consumes the entry this cycle.
- immediate_o  output  XLEN  sign-extended immediate.
- fmt_o  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- illegal_o  output  1  entry has an unrecognised opcode.
- illegal_cnt_o  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (asynchronous, reset=0): valid_o=0, immediate_o=0, fmt_o=0, illegal_o=0, illegal_cnt_o=0, skid entry empty, ready_o=1.
- Decode (combinational, on op=instruction_i[6:0]):
  - I-format, opcodes 0x13/0x03/0x67 (plus 0x73 if SUPPORT_SYSTEM): sext(instr[31:20]).
  - S-format, 0x23: sext({instr[31:25], instr[11:7]}).
  - B-format, 0x63: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-format, 0x37/0x17: sext({instr[31:12], 12'b0}).
  - J-format, 0x6F: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R-format, 0x33: immediate 0, legal.
  - Any other opcode: immediate 0, fmt 7, illegal 1.
  - All sign extension replicates instr[31] up to XLEN.
- Handshake:
  - Accept occurs when valid_i & ready_o & !flush_i.
  - Consume occurs when valid_o & ready_i.
  - Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 if the main register is free or being consumed.
- Skid buffer:
  - If the main register is held (valid_o & !ready_i) when an accept occurs, the decoded entry goes to the skid register.
  - ready_o is registered: ready_o = !skid_valid.
  - When the main entry is consumed and the skid entry is full, the skid entry moves to main the next cycle and ready_o rises the following cycle.
  - Entries leave in strict FIFO order; no drops, no duplicates.
- Throughput: with ready_i held at 1, one instruction per cycle, back to back.
- Flush:
  - flush_i=1 clears valid_o and the skid entry at the next edge.
  - An input presented in the same cycle is not accepted.
  - flush_i has priority over accept and consume.
  - flush_i does not change illegal_cnt_o.
- Illegal counter: increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W-1. It is cleared only by reset.
- Output stability: while valid_o=1 and ready_i=0, immediate_o, fmt_o and illegal_o hold.
- Reset asserted mid-transfer: all entries are lost and outputs return to reset values immediately.

Decomposition:
- Shared package imm_pkg holds:
  - the opcode constants (OP_IMM=0x13, LOAD=0x03, JALR=0x67, STORE=0x23, BRANCH=0x63, LUI=0x37, AUIPC=0x17, JAL=0x6F, OP=0x33, SYSTEM=0x73);
  - the format code constants FMT_R..FMT_ILLEGAL.
- Sub-module imm_decode: purely combinational decode of instruction to {immediate, fmt, illegal}, parametrised by XLEN and SUPPORT_SYSTEM.
- The top level instantiates imm_decode and contains the skid buffer, handshake and counter.

Test Plan:
- addi 0xFFF00093, ready_i=1 -> next cycle valid_o=1, immediate_o=0xFFFFFFFF, fmt_o=1, illegal_o=0.
- lui 0x123452B7 -> immediate_o=0x12345000, fmt_o=4. With XLEN=64, lui 0x800002B7 -> 0xFFFFFFFF80000000.
- beq 0xFE000EE3 -> immediate_o=0xFFFFFFFC, fmt_o=3. jal 0x0080006F -> immediate_o=0x00000008, fmt_o=5.
- Three back-to-back valid_i with ready_i=0 for 3 cycles:
  - first instruction held in main, second in skid, ready_o=0 from the following cycle, third not accepted;
  - after ready_i=1 the three entries come out in order with no loss.
- flush_i=1 while main and skid are full -> valid_o=0 and ready_o=1 one cycle later; the instruction presented during the flush cycle never appears.
- 300 accepted 0x0000007F words with CNT_W=8 -> each gives fmt_o=7, illegal_o=1, immediate_o=0; illegal_cnt_o ends at 255. Reset low -> counter reads 0 immediately.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode and format-code definitions for the decode-stage immediate generator.
package imm_pkg;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode: raw instruction to sign-extended immediate,
// format code and illegal-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit SUPPORT_SYSTEM = 1'b0
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] immediate,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32_s;
  logic [6:0]  op_s;

  assign op_s = instruction[6:0];

  // Opcode to format; every immediate is assembled as a signed 32-bit value first
  always_comb begin
    imm32_s = 32'd0;
    fmt     = FMT_ILLEGAL;
    illegal = 1'b1;
    case (op_s)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm32_s = {{20{instruction[31]}}, instruction[31:20]};
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OP_SYSTEM: begin
        if (SUPPORT_SYSTEM) begin
          imm32_s = {{20{instruction[31]}}, instruction[31:20]};
          fmt     = FMT_I;
          illegal = 1'b0;
        end else begin
          imm32_s = 32'd0;
          fmt     = FMT_ILLEGAL;
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        imm32_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        imm32_s = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};
        fmt     = FMT_B;
        illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        imm32_s = {instruction[31:12], 12'b0};
        fmt     = FMT_U;
        illegal = 1'b0;
      end
      OP_JAL: begin
        imm32_s = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
        fmt     = FMT_J;
        illegal = 1'b0;
      end
      OP_OP: begin
        imm32_s = 32'd0;
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      default: begin
        imm32_s = 32'd0;
        fmt     = FMT_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

  // Bit 31 of the 32-bit immediate is always instr[31], so widening to XLEN sign-extends it
  assign immediate = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: valid/ready input, decode, 2-entry skid buffer
// (main + skid) with flush, and a saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 8,
  parameter bit SUPPORT_SYSTEM = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instruction_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  immediate_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  entry_t          dec_s, main_r, main_n_s, skid_r, skid_n_s;
  logic            main_v_r, main_v_n_s, skid_v_r, skid_v_n_s, ready_r;
  logic            accept_s, consume_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;

  imm_decode #(
    .XLEN           (XLEN),
    .SUPPORT_SYSTEM (SUPPORT_SYSTEM)
  ) u_decode (
    .instruction (instruction_i),
    .immediate   (dec_s.imm),
    .fmt         (dec_s.fmt),
    .illegal     (dec_s.illegal)
  );

  assign accept_s  = valid_i & ready_r & ~flush_i;
  assign consume_s = main_v_r & ready_i;

  // Next-state for main/skid entries and the counter; flush wins over accept and consume
  always_comb begin
    main_n_s   = main_r;
    skid_n_s   = skid_r;
    main_v_n_s = main_v_r;
    skid_v_n_s = skid_v_r;
    cnt_n_s    = cnt_r;
    if (flush_i) begin
      main_v_n_s = 1'b0;
      skid_v_n_s = 1'b0;
    end else if (consume_s || !main_v_r) begin
      if (skid_v_r) begin
        main_n_s   = skid_r;
        main_v_n_s = 1'b1;
        skid_v_n_s = 1'b0;
      end else if (accept_s) begin
        main_n_s   = dec_s;
        main_v_n_s = 1'b1;
      end else begin
        main_v_n_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_n_s   = dec_s;
      skid_v_n_s = 1'b1;
    end else begin
      skid_v_n_s = skid_v_r;
    end
    if (accept_s && dec_s.illegal && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_n_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_n_s = cnt_r;
    end
  end

  // State registers; ready is registered as the inverse of the next skid occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_r   <= '{imm: {XLEN{1'b0}}, fmt: FMT_R, illegal: 1'b0};
      skid_r   <= '{imm: {XLEN{1'b0}}, fmt: FMT_R, illegal: 1'b0};
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
      ready_r  <= 1'b1;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      main_r   <= main_n_s;
      skid_r   <= skid_n_s;
      main_v_r <= main_v_n_s;
      skid_v_r <= skid_v_n_s;
      ready_r  <= ~skid_v_n_s;
      cnt_r    <= cnt_n_s;
    end
  end

  assign ready_o       = ready_r;
  assign valid_o       = main_v_r;
  assign immediate_o   = main_r.imm;
  assign fmt_o         = main_r.fmt;
  assign illegal_o     = main_r.illegal;
  assign illegal_cnt_o = cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit/no-SYSTEM and a 64-bit/SYSTEM instance
// share stimulus; expected entries come from an arithmetic reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush_i, valid_i, ready_i;
  logic [31:0] instruction_i;

  logic        rdy32, v32, ill32, rdy64, v64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [7:0]  cnt32, cnt64;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8), .SUPPORT_SYSTEM(1'b0)) dut32 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy32),
    .instruction_i(instruction_i), .valid_o(v32), .ready_i(ready_i),
    .immediate_o(imm32), .fmt_o(fmt32), .illegal_o(ill32), .illegal_cnt_o(cnt32));

  imm_gen_pipe #(.XLEN(64), .CNT_W(8), .SUPPORT_SYSTEM(1'b1)) dut64 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy64),
    .instruction_i(instruction_i), .valid_o(v64), .ready_i(ready_i),
    .immediate_o(imm64), .fmt_o(fmt64), .illegal_o(ill64), .illegal_cnt_o(cnt64));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] imm0, imm1;
    logic [2:0]  fmt0, fmt1;
  } exp_t;

  exp_t q[$];
  int   cnt0 = 0, cnt1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins, input bit sys);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return 3'd1;
      7'h73:               return sys ? 3'd1 : 3'd7;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      7'h33:               return 3'd0;
      default:             return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input bit sys);
    longint s;
    s = longint'($signed(ins));
    case (ref_fmt(ins, sys))
      3'd1: return s >>> 20;
      3'd2: return ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd3: return ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                   (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd4: return (s >>> 12) <<< 12;
      3'd5: return ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                   (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: compare consumed entries against the queue, track counters and hold stability
  logic        prev_hold = 1'b0;
  logic [63:0] prev_imm;
  logic [2:0]  prev_fmt;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      cnt0 = 0;
      cnt1 = 0;
      prev_hold = 1'b0;
    end else begin
      chk("cnt32", 64'(cnt32), 64'(cnt0));
      chk("cnt64", 64'(cnt64), 64'(cnt1));
      chk("valid64_vs_32", 64'(v64), 64'(v32));
      if (prev_hold) begin
        chk("hold_imm", imm64, prev_imm);
        chk("hold_fmt", 64'(fmt32), 64'(prev_fmt));
      end
      prev_hold = v32 && !ready_i && !flush_i;
      prev_imm  = imm64;
      prev_fmt  = fmt32;
      if (flush_i) begin
        q.delete();
      end else begin
        if (v32 && ready_i) begin
          if (q.size() == 0) begin
            chk("spurious_entry", 64'(v32), 64'd0);
          end else begin
            e = q.pop_front();
            chk("imm32", 64'(imm32), 64'(e.imm0[31:0]));
            chk("fmt32", 64'(fmt32), 64'(e.fmt0));
            chk("ill32", 64'(ill32), 64'(e.fmt0 == 3'd7));
            chk("imm64", imm64, e.imm1);
            chk("fmt64", 64'(fmt64), 64'(e.fmt1));
            chk("ill64", 64'(ill64), 64'(e.fmt1 == 3'd7));
          end
        end
        if (valid_i && rdy32) begin
          e.imm0 = ref_imm(instruction_i, 1'b0);
          e.imm1 = ref_imm(instruction_i, 1'b1);
          e.fmt0 = ref_fmt(instruction_i, 1'b0);
          e.fmt1 = ref_fmt(instruction_i, 1'b1);
          q.push_back(e);
          if (e.fmt0 == 3'd7 && cnt0 < 255) cnt0++;
          if (e.fmt1 == 3'd7 && cnt1 < 255) cnt1++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold valid_i until the DUT accepts it, bounded
  task automatic send(input logic [31:0] ins);
    int  n = 0;
    bit  taken;
    valid_i = 1'b1;
    instruction_i = ins;
    do begin
      taken = rdy32 && !flush_i;
      step();
      n++;
    end while (!taken && n < 100);
    if (!taken) chk("send_timeout", 64'd0, 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic directed(input logic [31:0] ins, input logic [63:0] e32, input logic [2:0] f);
    ready_i = 1'b1;
    send(ins);
    chk("dir_valid", 64'(v32), 64'd1);
    chk("dir_imm32", 64'(imm32), e32);
    chk("dir_fmt", 64'(fmt32), 64'(f));
  endtask

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F, 7'h00};

  initial begin
    logic [31:0] r;
    int n;
    reset = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; instruction_i = 32'd0;
    #12;
    chk("rst_valid", 64'(v32), 64'd0);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_fmt", 64'(fmt32), 64'd0);
    chk("rst_ill", 64'(ill32), 64'd0);
    chk("rst_cnt", 64'(cnt32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    reset = 1'b1;
    step();

    directed(32'hFFF00093, 64'hFFFFFFFF, 3'd1);
    directed(32'h123452B7, 64'h12345000, 3'd4);
    directed(32'hFE000EE3, 64'hFFFFFFFC, 3'd3);
    directed(32'h0080006F, 64'h00000008, 3'd5);
    directed(32'h800002B7, 64'h80000000, 3'd4);
    chk("lui_xlen64", imm64, 64'hFFFFFFFF80000000);
    step();

    // Backpressure: A to main, B to skid, C refused
    ready_i = 1'b0;
    valid_i = 1'b1; instruction_i = 32'hFFF00093; step();
    chk("skid_ready_after1", 64'(rdy32), 64'd1);
    instruction_i = 32'h123452B7; step();
    chk("skid_ready_full", 64'(rdy32), 64'd0);
    instruction_i = 32'h0080006F; step();
    chk("skid_ready_held", 64'(rdy32), 64'd0);
    chk("skid_main_is_A", 64'(imm32), 64'hFFFFFFFF);
    valid_i = 1'b0; ready_i = 1'b1;
    step(); step(); step();
    chk("skid_drained", 64'(v32), 64'd0);
    chk("skid_no_third", 64'(q.size()), 64'd0);

    // Flush with main and skid full
    ready_i = 1'b0;
    valid_i = 1'b1; instruction_i = 32'h00000013; step();
    instruction_i = 32'h00000033; step();
    flush_i = 1'b1; instruction_i = 32'h0080006F; step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_valid", 64'(v32), 64'd0);
    chk("flush_ready", 64'(rdy32), 64'd1);
    // Flush while ready_o=1: the concurrent input must be dropped
    valid_i = 1'b1; instruction_i = 32'h00000013; step();
    flush_i = 1'b1; instruction_i = 32'h0080006F; step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush2_valid", 64'(v32), 64'd0);
    ready_i = 1'b1; step();
    chk("flush2_no_entry", 64'(v32), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom();
      valid_i       = ($urandom_range(0, 3) != 0);
      ready_i       = ($urandom_range(0, 9) < 7);
      flush_i       = ($urandom_range(0, 24) == 0);
      instruction_i = {r[31:7], (r[3:0] < 4'd12) ? ops[r[3:0]] : r[6:0]};
      step();
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    n = 0;
    while ((v32 || q.size() != 0) && n < 20) begin step(); n++; end
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Saturating illegal counter
    valid_i = 1'b1; instruction_i = 32'h0000007F;
    for (int i = 0; i < 300; i++) step();
    valid_i = 1'b0;
    step(); step();
    chk("cnt_saturated", 64'(cnt32), 64'd255);
    chk("cnt64_saturated", 64'(cnt64), 64'd255);

    // Asynchronous reset mid-transfer
    ready_i = 1'b0; valid_i = 1'b1; instruction_i = 32'h00000013;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(v32), 64'd0);
    chk("midrst_cnt", 64'(cnt32), 64'd0);
    chk("midrst_ready", 64'(rdy32), 64'd1);
    chk("midrst_imm", imm64, 64'd0);
    valid_i = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    chk("post_rst_valid", 64'(v32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
